// File: rtl/fft_reorder_if.sv
// Sample-stream bundle between the FFT output and the reorder buffer; the slave
// modport is the reorder block's view. do_sof exists only with FFT_REORDER_SOF_EN.
interface fft_reorder_if #(
    parameter int WIDTH = 16
);
    logic             di_en;
    logic [WIDTH-1:0] di_re;
    logic [WIDTH-1:0] di_im;
    logic             do_en;
    logic [WIDTH-1:0] do_re;
    logic [WIDTH-1:0] do_im;
`ifdef FFT_REORDER_SOF_EN
    logic             do_sof;

    modport master (output di_en, di_re, di_im, input do_en, do_re, do_im, do_sof);
    modport slave  (input di_en, di_re, di_im, output do_en, do_re, do_im, do_sof);
`else
    modport master (output di_en, di_re, di_im, input do_en, do_re, do_im);
    modport slave  (input di_en, di_re, di_im, output do_en, do_re, do_im);
`endif
endinterface

// File: rtl/fft_reorder.sv
// Ping-pong reorder of bit-reversed FFT frames into natural order; FFT_REORDER_SOF_EN adds do_sof.
// First output 2 edges after a frame's last input; no backpressure (<=1 sample/cycle cannot overrun).
module fft_reorder #(
    parameter int LOG_N = 6,
    parameter int WIDTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    fft_reorder_if.slave  bus
);
    localparam int N = 2**LOG_N;

    typedef enum logic {IDLE, READ} state_t;

    state_t             state_q, state_d;
    logic [LOG_N-1:0]   wcnt_q, wcnt_d;
    logic [LOG_N-1:0]   rcnt_q, rcnt_d;
    logic               wsel_q, wsel_d;
    logic               rsel_q, rsel_d;
    logic [1:0]         full_q, full_d;
    logic               do_en_q, do_en_d;
    logic [WIDTH-1:0]   do_re_q, do_re_d;
    logic [WIDTH-1:0]   do_im_q, do_im_d;
`ifdef FFT_REORDER_SOF_EN
    logic               do_sof_q, do_sof_d;
`endif

    logic               rd_vld;
    logic [2*WIDTH-1:0] rd_dat;
    logic [LOG_N-1:0]   wr_addr;
    logic [2*WIDTH-1:0] mem_q [2][N];

    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
        logic [LOG_N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG_N; i++) r[i] = a[LOG_N-1-i];
        return r;
    endfunction

    assign wr_addr = bitrev(wcnt_q);
    assign rd_dat  = mem_q[rsel_q][rcnt_q];

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        rcnt_d   = rcnt_q;
        wsel_d   = wsel_q;
        rsel_d   = rsel_q;
        full_d   = full_q;
        rd_vld   = 1'b0;

        if (bus.di_en) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == {LOG_N{1'b1}}) begin
                full_d[wsel_q] = 1'b1;
                wsel_d         = ~wsel_q;
            end
        end

        // Write and read always sit on opposite banks, so the set above and the clear below never collide.
        case (state_q)
            IDLE: begin
                if (full_q[rsel_q]) begin
                    state_d = READ;
                    rcnt_d  = '0;
                end
            end
            READ: begin
                rd_vld = 1'b1;
                rcnt_d = rcnt_q + 1'b1;
                if (rcnt_q == {LOG_N{1'b1}}) begin
                    full_d[rsel_q] = 1'b0;
                    rsel_d         = ~rsel_q;
                    state_d        = full_q[~rsel_q] ? READ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        do_en_d = rd_vld;
        do_re_d = rd_vld ? rd_dat[2*WIDTH-1:WIDTH] : '0;
        do_im_d = rd_vld ? rd_dat[WIDTH-1:0]       : '0;
`ifdef FFT_REORDER_SOF_EN
        do_sof_d = rd_vld && (rcnt_q == '0);
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            wsel_q   <= 1'b0;
            rsel_q   <= 1'b0;
            full_q   <= '0;
            do_en_q  <= 1'b0;
            do_re_q  <= '0;
            do_im_q  <= '0;
`ifdef FFT_REORDER_SOF_EN
            do_sof_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            wsel_q   <= wsel_d;
            rsel_q   <= rsel_d;
            full_q   <= full_d;
            do_en_q  <= do_en_d;
            do_re_q  <= do_re_d;
            do_im_q  <= do_im_d;
`ifdef FFT_REORDER_SOF_EN
            do_sof_q <= do_sof_d;
`endif
        end
    end

    // Bank storage is deliberately not reset; the full flags gate every read.
    always_ff @(posedge clock) begin
        if (bus.di_en) mem_q[wsel_q][wr_addr] <= {bus.di_re, bus.di_im};
    end

    assign bus.do_en  = do_en_q;
    assign bus.do_re  = do_re_q;
    assign bus.do_im  = do_im_q;
`ifdef FFT_REORDER_SOF_EN
    assign bus.do_sof = do_sof_q;
`endif
endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: single, back-to-back, gapped, reset and extreme-value frames.
module tb_fft_reorder;
    localparam int W  = 16;
    localparam int LN = 6;
    localparam int N  = 64;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fft_reorder_if #(.WIDTH(W)) bus();

    fft_reorder #(.LOG_N(LN), .WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_cap = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Output monitor: sole owner of the capture state.
    logic [31:0] cap_q[$];
    int          rise_q[$];
    int          bursts    = 0;
    int          zero_viol = 0;
    logic        prev_en   = 1'b0;
`ifdef FFT_REORDER_SOF_EN
    logic [15:0] sof_q[$];
    int          sof_bad = 0;
`endif

    always @(negedge clock) begin
        if (bus.do_en === 1'b1) begin
            cap_q.push_back({bus.do_re, bus.do_im});
            if (!prev_en) begin
                bursts++;
                rise_q.push_back(cyc);
            end
        end else if (bus.do_re !== '0 || bus.do_im !== '0) begin
            zero_viol++;
        end
`ifdef FFT_REORDER_SOF_EN
        if (bus.do_sof === 1'b1) begin
            if (bus.do_en === 1'b1) sof_q.push_back(bus.do_re);
            else sof_bad++;
        end
`endif
        prev_en = (bus.do_en === 1'b1);
    end

    typedef struct {
        int          pos;
        logic [15:0] in_re;
        logic [15:0] in_im;
        int          out_n;
        logic [15:0] exp_re;
        logic [15:0] exp_im;
    } vec_t;

    vec_t vecs[7];

    function automatic int brev6(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 6; i++) if (v[i]) r |= (1 << (5 - i));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input int vbase, input bit gapped);
        logic [15:0] v;
        for (int k = 0; k < N; k++) begin
            v = 16'(vbase + k);
            bus.di_en = 1'b1;
            bus.di_re = v;
            bus.di_im = ~v;
            step();
            last_cap = cyc;
            if (gapped) begin
                bus.di_en = 1'b0;
                bus.di_re = 16'hDEAD;
                bus.di_im = 16'hBEEF;
                step();
            end
        end
    endtask

    task automatic idle_in();
        bus.di_en = 1'b0;
        bus.di_re = '0;
        bus.di_im = '0;
    endtask

    task automatic check_frames(input string name, input int base, input int vbase, input int nfr);
        logic [15:0] er;
        logic [31:0] act;
        for (int j = 0; j < nfr * N; j++) begin
            er  = 16'(vbase + (j / N) * N + brev6(j % N));
            act = (base + j < cap_q.size()) ? cap_q[base + j] : 32'hDEAD_BEEF;
            chk($sformatf("%s[%0d]", name, j), act, {er, ~er});
        end
    endtask

    task automatic check_burst(input string name, input int base_b, input int base_i, input int len);
        chk({name, "_bursts"}, 32'(bursts - base_b), 32'd1);
        chk({name, "_len"}, 32'(cap_q.size() - base_i), 32'(len));
    endtask

    initial begin
        int base_i, base_b, r;
        int nat_first[8];
        logic [15:0] fr_re[N];
        logic [15:0] fr_im[N];
`ifdef FFT_REORDER_SOF_EN
        int base_s;
`endif
        nat_first = '{0, 32, 16, 48, 8, 40, 24, 56};
        vecs[0] = '{1,  16'h8000, 16'h7FFF, 32, 16'h8000, 16'h7FFF};
        vecs[1] = '{62, 16'h7FFF, 16'h8000, 31, 16'h7FFF, 16'h8000};
        vecs[2] = '{0,  16'h5A5A, 16'hA5A5, 0,  16'h5A5A, 16'hA5A5};
        vecs[3] = '{2,  16'h1234, 16'hABCD, 16, 16'h1234, 16'hABCD};
        vecs[4] = '{3,  16'h0000, 16'hFFFF, 48, 16'h0000, 16'hFFFF};
        vecs[5] = '{5,  16'hFFFF, 16'h0000, 40, 16'hFFFF, 16'h0000};
        vecs[6] = '{63, 16'h0F0F, 16'hF0F0, 63, 16'h0F0F, 16'hF0F0};

        idle_in();
        repeat (3) step();
        chk("reset_do_en", 32'(bus.do_en), 32'd0);
        chk("reset_do_re", 32'(bus.do_re), 32'd0);
        chk("reset_do_im", 32'(bus.do_im), 32'd0);
        reset = 1'b0;
        repeat (2) step();

        // Single frame: latency, length, hand-derived order, full model check.
        base_i = cap_q.size();
        base_b = bursts;
        send_frame(0, 1'b0);
        idle_in();
        repeat (80) step();
        check_burst("single", base_b, base_i, N);
        r = (rise_q.size() > base_b) ? rise_q[base_b] : -1;
        chk("single_latency", 32'(r), 32'(last_cap + 2));
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("single_nat%0d", n),
                (base_i + n < cap_q.size()) ? {16'h0, cap_q[base_i + n][31:16]} : 32'hDEAD_BEEF,
                32'(nat_first[n]));
        end
        check_frames("single", base_i, 0, 1);

        // Three frames back to back: one contiguous 192-sample burst.
        base_i = cap_q.size();
        base_b = bursts;
`ifdef FFT_REORDER_SOF_EN
        base_s = sof_q.size();
`endif
        for (int f = 0; f < 3; f++) send_frame(f * N, 1'b0);
        idle_in();
        repeat (80) step();
        check_burst("b2b", base_b, base_i, 3 * N);
        check_frames("b2b", base_i, 0, 3);
`ifdef FFT_REORDER_SOF_EN
        chk("sof_count", 32'(sof_q.size() - base_s), 32'd3);
        for (int f = 0; f < 3; f++) begin
            chk($sformatf("sof_val%0d", f),
                (base_s + f < sof_q.size()) ? {16'h0, sof_q[base_s + f]} : 32'hDEAD_BEEF,
                32'(f * N));
        end
`endif

        // Gapped input still yields one contiguous burst.
        base_i = cap_q.size();
        base_b = bursts;
        send_frame(1000, 1'b1);
        idle_in();
        repeat (80) step();
        check_burst("gapped", base_b, base_i, N);
        check_frames("gapped", base_i, 1000, 1);

        // Extreme values and selected positions from the vector table.
        for (int k = 0; k < N; k++) begin
            fr_re[k] = 16'(2000 + k);
            fr_im[k] = ~fr_re[k];
        end
        for (int v = 0; v < 7; v++) begin
            fr_re[vecs[v].pos] = vecs[v].in_re;
            fr_im[vecs[v].pos] = vecs[v].in_im;
        end
        base_i = cap_q.size();
        base_b = bursts;
        for (int k = 0; k < N; k++) begin
            bus.di_en = 1'b1;
            bus.di_re = fr_re[k];
            bus.di_im = fr_im[k];
            step();
        end
        idle_in();
        repeat (80) step();
        check_burst("ext", base_b, base_i, N);
        for (int v = 0; v < 7; v++) begin
            chk($sformatf("ext_vec%0d", v),
                (base_i + vecs[v].out_n < cap_q.size()) ? cap_q[base_i + vecs[v].out_n] : 32'hDEAD_BEEF,
                {vecs[v].exp_re, vecs[v].exp_im});
        end

        // Reset while one burst is streaming and a second frame is partially written.
        send_frame(400, 1'b0);
        for (int k = 0; k < 20; k++) begin
            bus.di_en = 1'b1;
            bus.di_re = 16'(600 + k);
            bus.di_im = ~bus.di_re;
            step();
        end
        idle_in();
        chk("rst_pre_do_en", 32'(bus.do_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_do_en", 32'(bus.do_en), 32'd0);
        chk("rst_async_do_re", 32'(bus.do_re), 32'd0);
        chk("rst_async_do_im", 32'(bus.do_im), 32'd0);
        repeat (3) step();
        reset = 1'b0;
        base_i = cap_q.size();
        base_b = bursts;
        repeat (2) step();
        send_frame(700, 1'b0);
        idle_in();
        repeat (80) step();
        check_burst("rst", base_b, base_i, N);
        check_frames("rst", base_i, 700, 1);

        chk("zero_when_idle", 32'(zero_viol), 32'd0);
`ifdef FFT_REORDER_SOF_EN
        chk("sof_without_en", 32'(sof_bad), 32'd0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
